// File: rtl/fp_mult_if.sv
// Operand/result handshake bundle for fp_mult_pipe. The master side feeds operands and
// accepts results. The slave side is the multiplier.
interface fp_mult_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [4:0]   flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_mult_pipe.sv
// Pipelined IEEE-754 multiplier (DAZ/FTZ) with one global stall enable.
// Define FP_MULT_RNE_EN for round-to-nearest-even; otherwise it rounds toward zero.
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic      clk,
  input logic      rst,
  fp_mult_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int XW = EXP_W + 2;
  localparam logic [XW-1:0] BIAS    = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic [XW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};
  localparam logic [XW-1:0] EXP_ONE = {{(XW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_NAN  = 2'd1,
    CLS_INF  = 2'd2,
    CLS_ZERO = 2'd3
  } cls_t;

  // Returns {zero, inf, nan, snan}. Subnormals count as zero.
  function automatic logic [3:0] classify(input logic [W-1:0] x);
    logic exp_ones, exp_zero, frac_nz;
    exp_ones = &x[W-2:MAN_W];
    exp_zero = ~|x[W-2:MAN_W];
    frac_nz  = |x[MAN_W-1:0];
    return {exp_zero, exp_ones & ~frac_nz, exp_ones & frac_nz,
            exp_ones & frac_nz & ~x[MAN_W-1]};
  endfunction

  logic en_s;
  assign en_s         = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = en_s;

  // ---------------- stage 1: unpack / multiply ----------------
  logic [3:0]    ca_s, cb_s;
  logic          inf_zero_s;
  cls_t          cls1_s;
  logic          inv1_s;
  logic [PW-1:0] prod_s;
  logic [XW-1:0] exp_sum_s;

  assign ca_s       = classify(bus.a);
  assign cb_s       = classify(bus.b);
  assign inf_zero_s = (ca_s[2] & cb_s[3]) | (ca_s[3] & cb_s[2]);
  assign prod_s     = PW'({1'b1, bus.a[MAN_W-1:0]}) * PW'({1'b1, bus.b[MAN_W-1:0]});
  assign exp_sum_s  = XW'(bus.a[W-2:MAN_W]) + XW'(bus.b[W-2:MAN_W]) - BIAS;

  // Special-case priority: NaN / inf*zero, then inf, then zero.
  always_comb begin
    cls1_s = CLS_NORM;
    inv1_s = 1'b0;
    if (ca_s[1] | cb_s[1] | inf_zero_s) begin
      cls1_s = CLS_NAN;
      inv1_s = ca_s[0] | cb_s[0] | inf_zero_s;
    end else if (ca_s[2] | cb_s[2]) begin
      cls1_s = CLS_INF;
    end else if (ca_s[3] | cb_s[3]) begin
      cls1_s = CLS_ZERO;
    end else begin
      cls1_s = CLS_NORM;
    end
  end

  logic          v1_r, sign1_r, inv1_r;
  cls_t          cls1_r;
  logic [PW-1:0] prod1_r;
  logic [XW-1:0] exp1_r;

  // Stage 1 registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_r    <= 1'b0;
      sign1_r <= 1'b0;
      inv1_r  <= 1'b0;
      cls1_r  <= CLS_NORM;
      prod1_r <= '0;
      exp1_r  <= '0;
    end else if (en_s) begin
      v1_r    <= bus.in_valid;
      sign1_r <= bus.a[W-1] ^ bus.b[W-1];
      inv1_r  <= inv1_s;
      cls1_r  <= cls1_s;
      prod1_r <= prod_s;
      exp1_r  <= exp_sum_s;
    end
  end

  // ---------------- stage 2: normalise ----------------
  logic [MAN_W-1:0] frac_n_s;
  logic             guard_n_s, sticky_n_s;
  logic [XW-1:0]    exp_n_s;

  // A product in [2,4) shifts right by one; its lowest bit joins the sticky.
  always_comb begin
    frac_n_s   = '0;
    guard_n_s  = 1'b0;
    sticky_n_s = 1'b0;
    exp_n_s    = exp1_r + {{(XW-1){1'b0}}, prod1_r[PW-1]};
    if (prod1_r[PW-1]) begin
      frac_n_s   = prod1_r[PW-2 -: MAN_W];
      guard_n_s  = prod1_r[MAN_W];
      sticky_n_s = |prod1_r[MAN_W-1:0];
    end else begin
      frac_n_s   = prod1_r[PW-3 -: MAN_W];
      guard_n_s  = prod1_r[MAN_W-1];
      sticky_n_s = |prod1_r[MAN_W-2:0];
    end
  end

  logic             v2_r, sign2_r, inv2_r, guard2_r, sticky2_r;
  cls_t             cls2_r;
  logic [MAN_W-1:0] frac2_r;
  logic [XW-1:0]    exp2_r;

  // Stage 2 registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2_r      <= 1'b0;
      sign2_r   <= 1'b0;
      inv2_r    <= 1'b0;
      guard2_r  <= 1'b0;
      sticky2_r <= 1'b0;
      cls2_r    <= CLS_NORM;
      frac2_r   <= '0;
      exp2_r    <= '0;
    end else if (en_s) begin
      v2_r      <= v1_r;
      sign2_r   <= sign1_r;
      inv2_r    <= inv1_r;
      guard2_r  <= guard_n_s;
      sticky2_r <= sticky_n_s;
      cls2_r    <= cls1_r;
      frac2_r   <= frac_n_s;
      exp2_r    <= exp_n_s;
    end
  end

  // ---------------- stage 3: round ----------------
  logic           inc_s;
  logic [MAN_W:0] sum_s;
  logic [XW-1:0]  exp_r_s;

`ifdef FP_MULT_RNE_EN
  assign inc_s = guard2_r & (sticky2_r | frac2_r[0]);
`else
  assign inc_s = 1'b0;
`endif
  assign sum_s   = {1'b0, frac2_r} + {{MAN_W{1'b0}}, inc_s};
  assign exp_r_s = exp2_r + {{(XW-1){1'b0}}, sum_s[MAN_W]};

  logic             v3_r, sign3_r, inv3_r, inx3_r;
  cls_t             cls3_r;
  logic [MAN_W-1:0] frac3_r;
  logic [XW-1:0]    exp3_r;

  // Stage 3 registers. A rounding carry leaves the fraction at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v3_r    <= 1'b0;
      sign3_r <= 1'b0;
      inv3_r  <= 1'b0;
      inx3_r  <= 1'b0;
      cls3_r  <= CLS_NORM;
      frac3_r <= '0;
      exp3_r  <= '0;
    end else if (en_s) begin
      v3_r    <= v2_r;
      sign3_r <= sign2_r;
      inv3_r  <= inv2_r;
      inx3_r  <= guard2_r | sticky2_r;
      cls3_r  <= cls2_r;
      frac3_r <= sum_s[MAN_W-1:0];
      exp3_r  <= exp_r_s;
    end
  end

  // ---------------- pack / flags ----------------
  logic [W-1:0] res_s;
  logic [4:0]   flg_s;

  // Flags are {invalid, divbyzero, overflow, underflow, inexact}.
  always_comb begin
    res_s = '0;
    flg_s = 5'b00000;
    case (cls3_r)
      CLS_NAN: begin
        res_s = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        flg_s = {inv3_r, 4'b0000};
      end
      CLS_INF:  res_s = {sign3_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CLS_ZERO: res_s = {sign3_r, {(W-1){1'b0}}};
      CLS_NORM: begin
        if ($signed(exp3_r) >= $signed(EXP_MAX)) begin
`ifdef FP_MULT_RNE_EN
          res_s = {sign3_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
          res_s = {sign3_r, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif
          flg_s = 5'b00101;
        end else if ($signed(exp3_r) < $signed(EXP_ONE)) begin
          res_s = {sign3_r, {(W-1){1'b0}}};
          flg_s = 5'b00011;
        end else begin
          res_s = {sign3_r, exp3_r[EXP_W-1:0], frac3_r};
          flg_s = {4'b0000, inx3_r};
        end
      end
      default: begin
        res_s = '0;
        flg_s = 5'b00000;
      end
    endcase
  end

  logic         out_valid_r;
  logic [W-1:0] result_r;
  logic [4:0]   flags_r;

  // Output registers hold while the downstream stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      result_r    <= '0;
      flags_r     <= 5'b00000;
    end else if (en_s) begin
      out_valid_r <= v3_r;
      result_r    <= res_s;
      flags_r     <= flg_s;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.flags     = flags_r;
endmodule
